// File: rtl/aoi21_pipe_bank_if.sv
// Handshake/data bundle for aoi21_pipe_bank: input beat side plus output beat side.
// master = upstream/downstream environment, slave = the pipe bank itself.
interface aoi21_pipe_bank_if #(
   parameter int CH = 4,
   parameter int AW = 2
);
   logic             IN_VALID;
   logic             IN_READY;
   logic             MODE;
   logic [CH*AW-1:0] A;
   logic [CH-1:0]    B;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [CH-1:0]    ZN;

   modport master (
      output IN_VALID, MODE, A, B, OUT_READY,
      input  IN_READY, OUT_VALID, ZN
   );

   modport slave (
      input  IN_VALID, MODE, A, B, OUT_READY,
      output IN_READY, OUT_VALID, ZN
   );
endinterface

// File: rtl/aoi21_pipe_bank.sv
// CH-channel AOI/OAI function bank feeding a DEPTH-stage elastic valid/ready pipeline.
// Each stage advances when it is empty or the stage ahead of it advances.
module aoi21_pipe_bank_lane #(
   parameter int AW = 2
) (
   input  logic [AW-1:0] a,
   input  logic          b,
   input  logic          mode,
   output logic          zn
);
   always_comb zn = mode ? ~((|a) & b) : ~((&a) | b);
endmodule

module aoi21_pipe_bank #(
   parameter int CH    = 4,
   parameter int AW    = 2,
   parameter int DEPTH = 2
) (
   input logic              CLK,
   input logic              RST,
   aoi21_pipe_bank_if.slave bus
);
   if (DEPTH < 1) begin : g_bad_depth
      $error("aoi21_pipe_bank: DEPTH must be >= 1");
   end

   logic [CH-1:0]             f;
   logic [DEPTH-1:0]          v_q, v_d;
   logic [DEPTH-1:0][CH-1:0]  d_q, d_d;
   logic [DEPTH-1:0]          adv;
   logic                      stall_tail;

   for (genvar i = 0; i < CH; i++) begin : g_lane
      aoi21_pipe_bank_lane #(.AW(AW)) u_lane (
         .a    (bus.A[i*AW +: AW]),
         .b    (bus.B[i]),
         .mode (bus.MODE),
         .zn   (f[i])
      );
   end

   // Stage k is blocked only if it and every stage ahead are full and the sink stalls;
   // evaluated tail-first so the ripple stays inside one process.
   always_comb begin
      adv        = '0;
      stall_tail = ~bus.OUT_READY;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         stall_tail = stall_tail & v_q[k];
         adv[k]     = ~stall_tail;
      end
   end

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (adv[0]) begin
         v_d[0] = bus.IN_VALID;
         d_d[0] = f;
      end
      for (int k = 1; k < DEPTH; k++) begin
         if (adv[k]) begin
            v_d[k] = v_q[k-1];
            d_d[k] = d_q[k-1];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         v_q <= '0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign bus.IN_READY  = adv[0];
   assign bus.OUT_VALID = v_q[DEPTH-1];
   assign bus.ZN        = d_q[DEPTH-1];
endmodule

// File: tb/tb_aoi21_pipe_bank.sv
// Directed/table bench for aoi21_pipe_bank: function table, streaming, backpressure,
// random stalls with a scoreboard, mid-stream reset, and two parameter variants.
module tb_aoi21_pipe_bank;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aoi21_pipe_bank_if #(.CH(4), .AW(2)) bm ();
   aoi21_pipe_bank_if #(.CH(1), .AW(1)) bs ();
   aoi21_pipe_bank_if #(.CH(8), .AW(4)) bl ();

   aoi21_pipe_bank #(.CH(4), .AW(2), .DEPTH(2)) dut   (.CLK(clk), .RST(rst), .bus(bm));
   aoi21_pipe_bank #(.CH(1), .AW(1), .DEPTH(1)) dut_s (.CLK(clk), .RST(rst), .bus(bs));
   aoi21_pipe_bank #(.CH(8), .AW(4), .DEPTH(5)) dut_l (.CLK(clk), .RST(rst), .bus(bl));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] model(input logic m, input logic [7:0] a, input logic [3:0] b);
      logic [3:0] r;
      logic [1:0] g;
      for (int i = 0; i < 4; i++) begin
         g = a[2*i +: 2];
         r[i] = m ? ~((g[0] | g[1]) & b[i]) : ~((g[0] & g[1]) | b[i]);
      end
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
      #1;
   endtask

   // Scoreboard on the main DUT: push on accept, pop and compare on output transfer.
   logic [3:0] exp_q[$];
   int pushes = 0, outs = 0, run = 0, max_run = 0;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         run = 0;
      end else begin
         if (bm.IN_VALID && bm.IN_READY) begin
            exp_q.push_back(model(bm.MODE, bm.A, bm.B));
            pushes++;
         end
         if (bm.OUT_VALID) run++; else run = 0;
         if (run > max_run) max_run = run;
         if (bm.OUT_VALID && bm.OUT_READY) begin
            outs++;
            if (exp_q.size() == 0) chk("sb_extra_beat", 32'd1, 32'd0);
            else chk("sb_order", bm.ZN, exp_q.pop_front());
         end
      end
   end

   typedef struct {
      logic       mode;
      logic [7:0] a;
      logic [3:0] b;
      logic [3:0] zn;
   } vec_t;
   vec_t vt[6];

   task automatic drv(input logic v, input logic m, input logic [7:0] a, input logic [3:0] b);
      bm.IN_VALID = v;
      bm.MODE     = m;
      bm.A        = a;
      bm.B        = b;
   endtask

   task automatic lat_l(input logic m, input logic [31:0] a, input logic [7:0] b, input logic [7:0] zn);
      int lat;
      bit got;
      cyc();
      bl.IN_VALID = 1'b1; bl.MODE = m; bl.A = a; bl.B = b;
      smp();
      chk("l_in_ready", bl.IN_READY, 1);
      lat = 0; got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         cyc();
         bl.IN_VALID = 1'b0;
         lat++;
         smp();
         if (bl.OUT_VALID) got = 1;
      end
      chk("l_latency", lat, 5);
      chk("l_zn", bl.ZN, zn);
   endtask

   task automatic lat_s(input logic m, input logic a, input logic b, input logic zn);
      int lat;
      bit got;
      cyc();
      bs.IN_VALID = 1'b1; bs.MODE = m; bs.A = a; bs.B = b;
      smp();
      chk("s_in_ready", bs.IN_READY, 1);
      lat = 0; got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
         cyc();
         bs.IN_VALID = 1'b0;
         lat++;
         smp();
         if (bs.OUT_VALID) got = 1;
      end
      chk("s_latency", lat, 1);
      chk("s_zn", bs.ZN, zn);
   endtask

   initial begin
      int p0, o0, stalls, n;
      logic [3:0] held;

      // channel i of each row uses combo {A_i,B_i} listed low channel first
      vt[0] = '{1'b0, 8'b01_01_00_00, 4'b1010, 4'b0101};
      vt[1] = '{1'b0, 8'b11_11_10_10, 4'b1010, 4'b0001};
      vt[2] = '{1'b1, 8'b01_01_00_00, 4'b1010, 4'b0111};
      vt[3] = '{1'b1, 8'b11_11_10_10, 4'b1010, 4'b0101};
      vt[4] = '{1'b0, 8'h00,          4'b0000, 4'b1111};
      vt[5] = '{1'b1, 8'hFF,          4'b1111, 4'b0000};

      drv(1'b1, 1'b0, 8'h00, 4'h0);
      bm.OUT_READY = 1'b1;
      bs.IN_VALID = 1'b0; bs.MODE = 1'b0; bs.A = '0; bs.B = '0; bs.OUT_READY = 1'b1;
      bl.IN_VALID = 1'b0; bl.MODE = 1'b0; bl.A = '0; bl.B = '0; bl.OUT_READY = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      bm.IN_VALID = 1'b0;
      smp();
      chk("rst_out_valid", bm.OUT_VALID, 0);
      chk("rst_zn", bm.ZN, 0);
      chk("rst_in_ready", bm.IN_READY, 1);
      chk("rst_l_zn", bl.ZN, 0);
      chk("rst_s_out_valid", bs.OUT_VALID, 0);

      for (int i = 0; i < 6; i++) begin
         cyc();
         drv(1'b1, vt[i].mode, vt[i].a, vt[i].b);
         smp();
         chk("tbl_in_ready", bm.IN_READY, 1);
         cyc();
         bm.IN_VALID = 1'b0;
         smp();
         chk("tbl_not_early", bm.OUT_VALID, 0);
         cyc();
         smp();
         chk("tbl_out_valid", bm.OUT_VALID, 1);
         chk("tbl_zn", bm.ZN, vt[i].zn);
      end
      cyc(); cyc();

      max_run = 0; o0 = outs; stalls = 0;
      for (int i = 0; i < 16; i++) begin
         cyc();
         drv(1'b1, 1'b0, 8'h00, 4'(i));
         smp();
         if (!bm.IN_READY) stalls++;
      end
      cyc();
      bm.IN_VALID = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      smp();
      chk("stream_stalls", stalls, 0);
      chk("stream_run", max_run, 16);
      chk("stream_outs", outs - o0, 16);

      p0 = pushes;
      bm.OUT_READY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         drv(1'b1, 1'b0, 8'h00, 4'(i));
         smp();
      end
      chk("bp_accepted", pushes - p0, 2);
      chk("bp_in_ready", bm.IN_READY, 0);
      chk("bp_out_valid", bm.OUT_VALID, 1);
      chk("bp_zn_head", bm.ZN, 4'hF);
      held = bm.ZN;
      cyc();
      smp();
      chk("bp_zn_held", bm.ZN, held);
      cyc();
      bm.OUT_READY = 1'b1;
      bm.B = 4'h3;
      smp();
      chk("bp_release_in_ready", bm.IN_READY, 1);
      cyc();
      bm.OUT_READY = 1'b0;
      bm.IN_VALID  = 1'b0;
      smp();
      chk("bp_one_in", pushes - p0, 3);
      chk("bp_occupancy", bm.OUT_VALID, 1);
      chk("bp_next_head", bm.ZN, 4'hE);
      chk("bp_full_again", bm.IN_READY, 0);
      cyc();
      bm.OUT_READY = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      smp();
      chk("bp_drained", exp_q.size(), 0);

      p0 = pushes; o0 = outs; n = 0;
      while (pushes - p0 < 1000 && n < 20000) begin
         cyc();
         drv(($urandom_range(3) != 0), 1'($urandom), 8'($urandom), 4'($urandom));
         bm.OUT_READY = ($urandom_range(2) != 0);
         smp();
         n++;
      end
      chk("rand_budget", (n < 20000), 1);
      cyc();
      bm.IN_VALID  = 1'b0;
      bm.OUT_READY = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      smp();
      chk("rand_no_loss", outs - o0, pushes - p0);
      chk("rand_sb_empty", exp_q.size(), 0);

      bm.OUT_READY = 1'b0;
      for (int i = 0; i < 2; i++) begin
         cyc();
         drv(1'b1, 1'b0, 8'h00, 4'(i));
      end
      cyc();
      rst = 1'b1;
      bm.B = 4'h7;
      smp();
      cyc();
      rst = 1'b0;
      bm.IN_VALID = 1'b0;
      smp();
      chk("mrst_out_valid", bm.OUT_VALID, 0);
      chk("mrst_zn", bm.ZN, 0);
      chk("mrst_in_ready", bm.IN_READY, 1);
      o0 = outs;
      cyc();
      bm.OUT_READY = 1'b1;
      for (int i = 0; i < 6; i++) cyc();
      smp();
      chk("mrst_flushed", outs - o0, 0);

      lat_l(1'b0, 32'h0000_FFFF, 8'h00, 8'hF0);
      lat_l(1'b1, 32'h1000_0000, 8'h81, 8'h7F);
      lat_l(1'b0, 32'hFFFF_FFFF, 8'h00, 8'h00);
      lat_s(1'b1, 1'b0, 1'b1, 1'b1);
      lat_s(1'b0, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
